// File: rtl/switch_nxn_rr.sv
// N x N word switch: per-input FIFOs with one-hot destination check,
// per-output round-robin arbitration into a registered valid/ready output.
module switch_nxn_rr #(
    parameter int N_PORTS    = 2,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int DROP_CNT_W = 8
) (
    input  logic                         clk,
    input  logic                         resetN,
    input  logic [N_PORTS-1:0]           in_valid,
    output logic [N_PORTS-1:0]           in_ready,
    input  logic [N_PORTS*DATA_W-1:0]    in_data,
    input  logic [N_PORTS*N_PORTS-1:0]   in_da,
    output logic [N_PORTS-1:0]           out_valid,
    input  logic [N_PORTS-1:0]           out_ready,
    output logic [N_PORTS*DATA_W-1:0]    out_data,
    output logic [DROP_CNT_W-1:0]        drop_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int IDX_W = $clog2(N_PORTS);

    typedef logic [IDX_W-1:0] idx_t;

    logic [DATA_W-1:0]   fifo_data [N_PORTS][FIFO_DEPTH];
    idx_t                fifo_dest [N_PORTS][FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr    [N_PORTS];
    logic [PTR_W-1:0]    rd_ptr    [N_PORTS];
    logic [CNT_W-1:0]    count     [N_PORTS];
    idx_t                in_dest   [N_PORTS];
    idx_t                head_dest [N_PORTS];
    logic [DATA_W-1:0]   head_data [N_PORTS];
    logic [N_PORTS-1:0]  accept, push, pop, drop;

    logic [N_PORTS-1:0]  out_free, grant_vld;
    idx_t                grant_src  [N_PORTS];
    idx_t                rr_ptr     [N_PORTS];
    logic [DATA_W-1:0]   out_data_q [N_PORTS];
    logic [DROP_CNT_W-1:0] drop_next;

    function automatic logic is_onehot(input logic [N_PORTS-1:0] v);
        return (v != '0) && ((v & (v - N_PORTS'(1))) == '0);
    endfunction

    function automatic idx_t encode(input logic [N_PORTS-1:0] v);
        idx_t idx;
        idx = '0;
        for (int k = 0; k < N_PORTS; k++)
            if (v[k]) idx = idx_t'(k);
        return idx;
    endfunction

    // No write-bypass: a full FIFO refuses a word even when it pops this cycle.
    always_comb begin
        for (int i = 0; i < N_PORTS; i++) begin
            in_ready[i]  = resetN && (count[i] != CNT_W'(FIFO_DEPTH));
            accept[i]    = in_valid[i] && in_ready[i];
            push[i]      = accept[i] && is_onehot(in_da[i*N_PORTS +: N_PORTS]);
            drop[i]      = accept[i] && !is_onehot(in_da[i*N_PORTS +: N_PORTS]);
            in_dest[i]   = encode(in_da[i*N_PORTS +: N_PORTS]);
            head_dest[i] = fifo_dest[i][rd_ptr[i]];
            head_data[i] = fifo_data[i][rd_ptr[i]];
        end
    end

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin : arbitrate
        int cand;
        grant_vld = '0;
        pop       = '0;
        for (int j = 0; j < N_PORTS; j++) begin
            grant_src[j] = '0;
            out_free[j]  = !out_valid[j] || out_ready[j];
            for (int k = 0; k < N_PORTS; k++) begin
                cand = (int'(rr_ptr[j]) + k) % N_PORTS;
                if (out_free[j] && !grant_vld[j] && count[cand] != '0 &&
                    head_dest[cand] == idx_t'(j)) begin
                    grant_vld[j] = 1'b1;
                    grant_src[j] = idx_t'(cand);
                    pop[cand]    = 1'b1;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < N_PORTS; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < N_PORTS; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
                count[i] <= count[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
            end
        end
    end

    // NOTE: FIFO storage has no reset; the counts guarantee stale entries are never read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_PORTS; i++) begin
            if (push[i]) begin
                fifo_data[i][wr_ptr[i]] <= in_data[i*DATA_W +: DATA_W];
                fifo_dest[i][wr_ptr[i]] <= in_dest[i];
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            out_valid <= '0;
            for (int j = 0; j < N_PORTS; j++) begin
                out_data_q[j] <= '0;
                rr_ptr[j]     <= '0;
            end
        end else begin
            for (int j = 0; j < N_PORTS; j++) begin
                if (out_free[j]) begin
                    if (grant_vld[j]) begin
                        out_data_q[j] <= head_data[grant_src[j]];
                        out_valid[j]  <= 1'b1;
                        rr_ptr[j]     <= idx_t'((int'(grant_src[j]) + 1) % N_PORTS);
                    end else begin
                        out_valid[j]  <= 1'b0;
                    end
                end
            end
        end
    end

    // Several inputs may drop in one cycle; each drop saturates individually.
    always_comb begin
        drop_next = drop_cnt;
        for (int i = 0; i < N_PORTS; i++)
            if (drop[i] && drop_next != '1) drop_next = drop_next + 1'b1;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) drop_cnt <= '0;
        else         drop_cnt <= drop_next;
    end

    always_comb begin
        out_data = '0;
        for (int j = 0; j < N_PORTS; j++)
            out_data[j*DATA_W +: DATA_W] = out_data_q[j];
    end

endmodule

// File: tb/tb_switch_nxn_rr.sv
// Randomized bench for switch_nxn_rr against a queue-based cycle model
// of the switching rules, plus directed scenarios for the key behaviours.
module tb_switch_nxn_rr;

    localparam int NP    = 2;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int DCW   = 8;
    localparam int DMAX  = (1 << DCW) - 1;

    logic              clk = 1'b0;
    logic              resetN;
    logic [NP-1:0]     in_valid, in_ready, out_valid, out_ready;
    logic [NP*DW-1:0]  in_data, out_data;
    logic [NP*NP-1:0]  in_da;
    logic [DCW-1:0]    drop_cnt;

    switch_nxn_rr #(.N_PORTS(NP), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .DROP_CNT_W(DCW)) dut (
        .clk(clk), .resetN(resetN),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_da(in_da),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        int            dest;
    } word_t;

    word_t         mq[NP][$];
    bit            mvalid [NP];
    logic [DW-1:0] mdata  [NP];
    int            mrr    [NP];
    int            mdrop;
    int            checks = 0;
    int            errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NP; i++) begin
            mq[i].delete();
            mvalid[i] = 1'b0;
            mdata[i]  = '0;
            mrr[i]    = 0;
        end
        mdrop = 0;
    endtask

    // Advances the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        bit acc [NP];
        bit gv  [NP];
        int gs  [NP];
        for (int i = 0; i < NP; i++) acc[i] = in_valid[i] && (mq[i].size() < DEPTH);
        for (int j = 0; j < NP; j++) begin
            gv[j] = 1'b0;
            gs[j] = 0;
            if (!mvalid[j] || out_ready[j]) begin
                for (int k = 0; k < NP; k++) begin
                    int s = (mrr[j] + k) % NP;
                    if (!gv[j] && mq[s].size() > 0 && mq[s][0].dest == j) begin
                        gv[j] = 1'b1;
                        gs[j] = s;
                    end
                end
                if (gv[j]) begin
                    mdata[j]  = mq[gs[j]][0].data;
                    mvalid[j] = 1'b1;
                    mrr[j]    = (gs[j] + 1) % NP;
                end else begin
                    mvalid[j] = 1'b0;
                end
            end
        end
        for (int j = 0; j < NP; j++) if (gv[j]) void'(mq[gs[j]].pop_front());
        for (int i = 0; i < NP; i++) begin
            if (acc[i]) begin
                logic [NP-1:0] da;
                int ones, idx;
                word_t w;
                da = in_da[i*NP +: NP];
                ones = 0;
                idx = 0;
                for (int k = 0; k < NP; k++) if (da[k]) begin ones++; idx = k; end
                if (ones == 1) begin
                    w.data = in_data[i*DW +: DW];
                    w.dest = idx;
                    mq[i].push_back(w);
                end else if (mdrop < DMAX) begin
                    mdrop++;
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int j = 0; j < NP; j++) begin
            check($sformatf("out_valid[%0d]", j), 64'(out_valid[j]), 64'(mvalid[j]));
            check($sformatf("out_data[%0d]", j), 64'(out_data[j*DW +: DW]), 64'(mdata[j]));
        end
        for (int i = 0; i < NP; i++)
            check($sformatf("in_ready[%0d]", i), 64'(in_ready[i]), 64'(mq[i].size() < DEPTH));
        check("drop_cnt", 64'(drop_cnt), 64'(mdrop));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic set_in(input int i, input bit v, input logic [DW-1:0] d, input logic [NP-1:0] da);
        in_valid[i]        = v;
        in_data[i*DW +: DW] = d;
        in_da[i*NP +: NP]  = da;
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < NP; i++) set_in(i, 1'b0, '0, '0);
    endtask

    initial begin
        logic [DW-1:0] w3 [6];
        logic [DW-1:0] held;
        logic [7:0]    srcs[$];
        logic [NP-1:0] da;
        int sent, xfers, r;
        bit rdy;

        resetN    = 1'b0;
        out_ready = '0;
        idle_inputs();
        model_reset();
        #2;
        check("reset out_valid", 64'(out_valid), 64'(0));
        check("reset out_data", 64'(out_data), 64'(0));
        check("reset drop_cnt", 64'(drop_cnt), 64'(0));
        check("reset in_ready", 64'(in_ready), 64'(0));
        #20 resetN = 1'b1;
        @(posedge clk);
        #1;
        compare_all();

        // 1: single word to output 1
        out_ready = 2'b11;
        set_in(0, 1'b1, 32'hA5A5_A5A5, 2'b10);
        tick();
        idle_inputs();
        tick();
        check("t1 out_valid", 64'(out_valid), 64'(2'b10));
        check("t1 out_data1", 64'(out_data[DW +: DW]), 64'h0000_0000_A5A5_A5A5);
        tick();

        // 2: both inputs stream into output 0, grants alternate
        for (int c = 0; c < 12; c++) begin
            for (int i = 0; i < NP; i++) set_in(i, 1'b1, {8'(i), 24'(c)}, 2'b01);
            tick();
            if (out_valid[0]) srcs.push_back(out_data[31:24]);
        end
        idle_inputs();
        for (int c = 0; c < 12; c++) begin
            tick();
            if (out_valid[0]) srcs.push_back(out_data[31:24]);
        end
        for (int k = 0; k < 4; k++)
            check($sformatf("t2 grant%0d", k), 64'(srcs[k]), 64'(k % 2));

        // 3: stalled output 1 fills register plus FIFO, then drains
        out_ready = 2'b01;
        for (int k = 0; k < 6; k++) w3[k] = {8'h30, 8'(k), 16'($urandom)};
        sent = 0;
        for (int c = 0; c < 12; c++) begin
            if (sent < 6) set_in(1, 1'b1, w3[sent], 2'b10);
            else          set_in(1, 1'b0, '0, '0);
            rdy = in_valid[1] && in_ready[1];
            tick();
            if (rdy) sent++;
        end
        check("t3 accepted", 64'(sent), 64'(5));
        check("t3 in_ready1", 64'(in_ready[1]), 64'(0));
        held = out_data[DW +: DW];
        for (int c = 0; c < 3; c++) begin
            tick();
            check("t3 stable", 64'(out_data[DW +: DW]), 64'(w3[0]));
        end
        check("t3 held", 64'(held), 64'(w3[0]));
        out_ready = 2'b11;
        xfers = 0;
        for (int c = 0; c < 12; c++) begin
            if (sent < 6) set_in(1, 1'b1, w3[sent], 2'b10);
            else          set_in(1, 1'b0, '0, '0);
            rdy = in_valid[1] && in_ready[1];
            if (out_valid[1] && out_ready[1]) xfers++;
            tick();
            if (rdy) sent++;
        end
        check("t3 drained", 64'(xfers), 64'(6));

        // 4: bad destinations are dropped with a saturating count
        set_in(0, 1'b1, 32'hDEAD_0000, 2'b00);
        tick();
        set_in(0, 1'b1, 32'hDEAD_0001, 2'b11);
        tick();
        check("t4 drop2", 64'(drop_cnt), 64'(2));
        for (int c = 0; c < 300; c++) begin
            set_in(0, 1'b1, $urandom, ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00);
            tick();
        end
        idle_inputs();
        tick();
        check("t4 saturated", 64'(drop_cnt), 64'(DMAX));
        check("t4 no output", 64'(out_valid), 64'(0));

        // 5: crossed paths in the same cycle
        set_in(0, 1'b1, 32'h5000_0001, 2'b10);
        set_in(1, 1'b1, 32'h5000_0010, 2'b01);
        tick();
        idle_inputs();
        tick();
        check("t5 both valid", 64'(out_valid), 64'(2'b11));

        // 6: reset mid-burst
        out_ready = 2'b00;
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < NP; i++) set_in(i, 1'b1, $urandom, 2'(1 << $urandom_range(0, NP-1)));
            tick();
        end
        #3 resetN = 1'b0;
        #1;
        check("t6 out_valid", 64'(out_valid), 64'(0));
        check("t6 drop_cnt", 64'(drop_cnt), 64'(0));
        check("t6 in_ready", 64'(in_ready), 64'(0));
        idle_inputs();
        model_reset();
        out_ready = 2'b11;
        #2 resetN = 1'b1;
        @(posedge clk);
        #1;
        compare_all();
        set_in(0, 1'b1, 32'h6000_0006, 2'b01);
        tick();
        idle_inputs();
        check("t6 not yet", 64'(out_valid), 64'(0));
        tick();
        check("t6 latency1", 64'(out_valid), 64'(2'b01));
        check("t6 data", 64'(out_data[0 +: DW]), 64'h0000_0000_6000_0006);

        // Random traffic
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NP; i++) begin
                r = $urandom_range(0, 9);
                if (r < 8) da = 2'(1 << $urandom_range(0, NP-1));
                else       da = 2'($urandom);
                set_in(i, $urandom_range(0, 3) != 0, $urandom, da);
            end
            for (int j = 0; j < NP; j++) out_ready[j] = $urandom_range(0, 9) < 7;
            tick();
        end
        idle_inputs();
        out_ready = 2'b11;
        for (int c = 0; c < 12; c++) tick();
        check("final idle", 64'(out_valid), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
